// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and as/ds/da handshake sequencer for the
// shared 8-bit-address / 16-bit-data strobe bus.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   req/req_rw          per-requester request level and direction (1=read)
//   req_addr/req_wdata  per-requester address and write data, packed by slice
//   gnt                 one-hot grant, held for the whole transaction
//   done/err            completion pulse to the winner, timeout flag
//   rdata               last captured read data
//   bus_addr/bus_as/bus_rw/bus_ds/bus_wdata  master side of the strobe bus
//   bus_da/bus_data     acknowledge and read data from the bus manager

package bus_arbiter_pkg;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_STROBE,
    S_RELEASE
  } state_t;

  // Request payload as latched at grant time
  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_req_t;
endpackage

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_rw,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               err,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      bus_addr,
  output logic               bus_as,
  output logic               bus_rw,
  output logic               bus_ds,
  output logic [DW-1:0]      bus_wdata,
  input  logic               bus_da,
  input  logic [DW-1:0]      bus_data
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_RST  = IW'(NREQ - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last;

  logic [NREQ-1:0] gnt_d, done_d;
  logic            err_d;
  logic [DW-1:0]   rdata_d, wdata_d;
  logic [AW-1:0]   addr_d;
  logic            as_d, rw_d, ds_d;

  bus_req_t        reqs [NREQ];
  bus_req_t        sel;
  logic [IW-1:0]   win;
  logic            any_req;

  // Unpack the flat request buses into one payload per requester
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign reqs[g] = '{rw:    req_rw[g],
                       addr:  req_addr[AW*g +: AW],
                       wdata: req_wdata[DW*g +: DW]};
  end

  assign sel      = reqs[win];
  assign cnt_last = (cnt_q == CNT_LAST);

  // Round-robin pick: first set req bit after ptr, wrapping; last winner is lowest
  always_comb begin : arbitrate
    int unsigned idx;
    idx     = 0;
    win     = ptr_q;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!any_req && req[IW'(idx)]) begin
        any_req = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= PTR_RST;
      cnt_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      bus_addr  <= '0;
      bus_as    <= 1'b0;
      bus_rw    <= 1'b0;
      bus_ds    <= 1'b0;
      bus_wdata <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      done      <= done_d;
      err       <= err_d;
      rdata     <= rdata_d;
      bus_addr  <= addr_d;
      bus_as    <= as_d;
      bus_rw    <= rw_d;
      bus_ds    <= ds_d;
      bus_wdata <= wdata_d;
    end
  end

  // Next-state logic
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (any_req) state_d = S_ADDR;
      S_ADDR:    state_d = S_STROBE;
      S_STROBE:  if (bus_da || cnt_last) state_d = S_RELEASE;
      S_RELEASE: if (!bus_da || cnt_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and timeout counter
  always_comb begin : next_outputs
    gnt_d   = gnt;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata;
    addr_d  = bus_addr;
    as_d    = bus_as;
    rw_d    = bus_rw;
    ds_d    = bus_ds;
    wdata_d = bus_wdata;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = NREQ'(1) << win;
          addr_d  = sel.addr;
          rw_d    = sel.rw;
          wdata_d = sel.wdata;
          as_d    = 1'b1;
          ptr_d   = win;
        end
      end
      S_ADDR: begin
        ds_d  = 1'b1;
        cnt_d = '0;
      end
      S_STROBE: begin
        if (bus_da) begin
          if (bus_rw) rdata_d = bus_data;
          done_d = gnt;
          as_d   = 1'b0;
          ds_d   = 1'b0;
          cnt_d  = '0;
        end else if (cnt_last) begin
          // Manager never acknowledged: complete with error, keep old rdata
          done_d = gnt;
          err_d  = 1'b1;
          as_d   = 1'b0;
          ds_d   = 1'b0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        if (!bus_da) begin
          gnt_d = '0;
        end else if (cnt_last) begin
          // da stuck high: flag it and free the bus anyway
          gnt_d = '0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
